// File: rtl/priority_sort_queue.sv
// Systolic priority queue: DEPTH sort cells kept in rank order, head at cell 0.
// Single-cycle insert, pop, or both; equal entries keep arrival order.
module priority_sort_queue #(
    parameter int DATA_W  = 32,
    parameter int KEY_HI  = 19,
    parameter int KEY_LO  = 12,
    parameter int TIE_HI  = 11,
    parameter int TIE_LO  = 0,
    parameter int DEPTH   = 8,
    parameter bit DESCEND = 1'b1,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DEPTH-1:0]             valid, valid_n, sv_valid;
    logic [DEPTH-1:0][DATA_W-1:0] data, data_n, sv_data;
    logic [DEPTH-1:0]             wins, swins;
    logic [CNT_W-1:0]             count_n;
    logic                         ins_fire, pop_fire;
    logic                         seen, prev_valid;
    logic [DATA_W-1:0]            prev_data;

    // Strict outrank; an equal key and tie never beats, which gives FIFO order.
    function automatic logic beats(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
        logic [KEY_HI-KEY_LO:0] ka, kb;
        logic [TIE_HI-TIE_LO:0] ta, tb;
        ka = a[KEY_HI:KEY_LO];
        kb = b[KEY_HI:KEY_LO];
        ta = a[TIE_HI:TIE_LO];
        tb = b[TIE_HI:TIE_LO];
        if (DESCEND) return (ka > kb) || ((ka == kb) && (ta > tb));
        else         return (ka < kb) || ((ka == kb) && (ta < tb));
    endfunction

    assign pop_fire  = en & pop & out_valid;
    assign in_ready  = en & (~full | pop_fire);
    assign ins_fire  = in_valid & in_ready;
    assign out_data  = data[0];

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            sv_valid[i] = valid[i+1];
            sv_data[i]  = data[i+1];
        end
        sv_valid[DEPTH-1] = 1'b0;
        sv_data[DEPTH-1]  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wins[i]  = ~valid[i] | beats(in_data, data[i]);
            swins[i] = ~sv_valid[i] | beats(in_data, sv_data[i]);
        end
    end

    always_comb begin
        valid_n    = valid;
        data_n     = data;
        seen       = 1'b0;
        prev_valid = 1'b0;
        prev_data  = '0;
        if (ins_fire && !pop_fire) begin
            // Cells at and after p form a contiguous run of wins.
            for (int i = 0; i < DEPTH; i++) begin
                if (wins[i]) begin
                    if (!seen) begin
                        valid_n[i] = 1'b1;
                        data_n[i]  = in_data;
                        seen       = 1'b1;
                    end else begin
                        valid_n[i] = prev_valid;
                        data_n[i]  = prev_data;
                    end
                end
                prev_valid = valid[i];
                prev_data  = data[i];
            end
        end else if (pop_fire && !ins_fire) begin
            valid_n = sv_valid;
            data_n  = sv_data;
        end else if (pop_fire && ins_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!seen) begin
                    if (swins[i]) begin
                        valid_n[i] = 1'b1;
                        data_n[i]  = in_data;
                        seen       = 1'b1;
                    end else begin
                        valid_n[i] = sv_valid[i];
                        data_n[i]  = sv_data[i];
                    end
                end
            end
        end
    end

    always_comb begin
        count_n = count;
        if (ins_fire && !pop_fire) count_n = count + CNT_W'(1);
        if (pop_fire && !ins_fire) count_n = count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            data      <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            valid     <= valid_n;
            data      <= data_n;
            count     <= count_n;
            full      <= (count_n == CNT_W'(DEPTH));
            empty     <= (count_n == '0);
            out_valid <= (count_n != '0);
        end
    end

endmodule

// File: tb/tb_priority_sort_queue.sv
// Bench for priority_sort_queue: descending and ascending instances,
// popped heads checked against a queue of hand-computed values.
module tb_priority_sort_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        d_en = 1'b1, d_in_valid = 1'b0, d_pop = 1'b0;
    logic [31:0] d_in_data = '0;
    logic        d_in_ready, d_out_valid, d_full, d_empty;
    logic [31:0] d_out_data;
    logic [3:0]  d_count;

    logic        a_en = 1'b1, a_in_valid = 1'b0, a_pop = 1'b0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_full, a_empty;
    logic [31:0] a_out_data;
    logic [3:0]  a_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_d[$];
    logic [31:0] q_a[$];

    always #5 clk = ~clk;

    priority_sort_queue #(.DESCEND(1'b1)) u_d (
        .clk(clk), .rst(rst), .en(d_en),
        .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
        .pop(d_pop), .out_valid(d_out_valid), .out_data(d_out_data),
        .count(d_count), .full(d_full), .empty(d_empty)
    );

    priority_sort_queue #(.DESCEND(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(a_en),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .pop(a_pop), .out_valid(a_out_valid), .out_data(a_out_data),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Head consumed on each accepted pop is compared with the scoreboard.
    always @(negedge clk) begin
        if (!rst && d_en && d_pop && d_out_valid) begin
            checks++;
            if (q_d.size() == 0) begin
                errors++;
                $display("FAIL d_pop_unexpected: got %h expected none",
                         d_out_data);
            end else begin
                logic [31:0] e;
                e = q_d.pop_front();
                if (d_out_data !== e) begin
                    errors++;
                    $display("FAIL d_pop: got %h expected %h", d_out_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && a_en && a_pop && a_out_valid) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_pop_unexpected: got %h expected none",
                         a_out_data);
            end else begin
                logic [31:0] e;
                e = q_a.pop_front();
                if (a_out_data !== e) begin
                    errors++;
                    $display("FAIL a_pop: got %h expected %h", a_out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_ins(input logic [31:0] v);
        d_in_valid = 1'b1;
        d_in_data  = v;
        tick();
        d_in_valid = 1'b0;
    endtask

    task automatic d_drain(input int n);
        d_pop = 1'b1;
        repeat (n) tick();
        d_pop = 1'b0;
    endtask

    initial begin
        logic [31:0] tie_exp [3];
        tie_exp[0] = 32'h2000_5009;
        tie_exp[1] = 32'h3000_5009;
        tie_exp[2] = 32'h1000_5003;

        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(d_out_valid), 32'd0);
        chk("rst_out_data", d_out_data, 32'h0);
        chk("rst_count", 32'(d_count), 32'd0);
        chk("rst_empty", 32'(d_empty), 32'd1);
        chk("rst_full", 32'(d_full), 32'd0);
        chk("rst_in_ready", 32'(d_in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Descending order
        d_ins(32'h0000_5000);
        d_ins(32'h0002_0000);
        d_ins(32'h0001_1000);
        chk("desc_count", 32'(d_count), 32'd3);
        chk("desc_head", d_out_data, 32'h0002_0000);
        q_d.push_back(32'h0002_0000);
        q_d.push_back(32'h0001_1000);
        q_d.push_back(32'h0000_5000);
        d_drain(3);
        chk("desc_empty", 32'(d_empty), 32'd1);
        chk("desc_out_valid", 32'(d_out_valid), 32'd0);

        // Tie-break and stability
        d_ins(32'h1000_5003);
        d_ins(32'h2000_5009);
        d_ins(32'h3000_5009);
        for (int i = 0; i < 3; i++) q_d.push_back(tie_exp[i]);
        d_drain(3);

        // Full, blocked insert, then insert+pop while full
        for (int k = 1; k <= 8; k++) d_ins(32'(k) << 12);
        chk("full_flag", 32'(d_full), 32'd1);
        chk("full_count", 32'(d_count), 32'd8);
        chk("full_in_ready", 32'(d_in_ready), 32'd0);
        d_ins(32'h0009_9000);
        chk("full_blocked_count", 32'(d_count), 32'd8);
        chk("full_blocked_head", d_out_data, 32'h0000_8000);
        q_d.push_back(32'h0000_8000);
        d_in_valid = 1'b1;
        d_in_data  = 32'h000F_F000;
        d_pop      = 1'b1;
        #1;
        chk("full_pop_in_ready", 32'(d_in_ready), 32'd1);
        tick();
        d_in_valid = 1'b0;
        d_pop      = 1'b0;
        chk("swap_head", d_out_data, 32'h000F_F000);
        chk("swap_count", 32'(d_count), 32'd8);
        chk("swap_full", 32'(d_full), 32'd1);
        q_d.push_back(32'h000F_F000);
        for (int k = 7; k >= 1; k--) q_d.push_back(32'(k) << 12);
        d_drain(8);
        chk("drain_empty", 32'(d_empty), 32'd1);

        // Ascending mode
        a_in_valid = 1'b1;
        a_in_data = 32'h0003_0000; tick();
        a_in_data = 32'h0000_2000; tick();
        a_in_data = 32'h0001_7000; tick();
        a_in_valid = 1'b0;
        chk("asc_head", a_out_data, 32'h0000_2000);
        q_a.push_back(32'h0000_2000);
        q_a.push_back(32'h0001_7000);
        q_a.push_back(32'h0003_0000);
        a_pop = 1'b1;
        repeat (5) tick();
        a_pop = 1'b0;
        chk("asc_empty_pop_count", 32'(a_count), 32'd0);
        chk("asc_empty_pop_empty", 32'(a_empty), 32'd1);

        // Enable low holds everything; reset clears at once
        d_ins(32'h0004_0000);
        d_ins(32'h0003_0000);
        d_ins(32'h0002_0000);
        d_ins(32'h0001_0000);
        d_en       = 1'b0;
        d_in_valid = 1'b1;
        d_in_data  = 32'h000A_0000;
        d_pop      = 1'b1;
        #1;
        chk("en0_in_ready", 32'(d_in_ready), 32'd0);
        tick();
        tick();
        chk("en0_count", 32'(d_count), 32'd4);
        chk("en0_head", d_out_data, 32'h0004_0000);
        d_in_valid = 1'b0;
        d_pop      = 1'b0;
        d_en       = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", 32'(d_count), 32'd0);
        chk("midrst_out_valid", 32'(d_out_valid), 32'd0);
        chk("midrst_out_data", d_out_data, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        chk("d_queue_drained", 32'(q_d.size()), 32'd0);
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
